// File: rtl/freelist_pkg.sv
// Shared types and helpers for the physical-register free-list controller.
// Pointers carry one wrap bit above the RAM index so full and empty are distinguishable.
package freelist_pkg;

  localparam int FL_DW        = 4;
  localparam int FL_CW        = 4;
  localparam int FL_DEPTH     = 64;
  localparam int FL_INDEX     = 6;
  localparam int FL_WIDTH     = 7;
  localparam int FL_ARCH_REGS = 32;

  typedef logic [FL_INDEX:0] fl_ptr_t;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_e;

  // Occupancy between two wrapped pointers; modulo arithmetic handles the wrap bit.
  function automatic fl_ptr_t ptr_diff(input fl_ptr_t a, input fl_ptr_t b);
    return fl_ptr_t'(a - b);
  endfunction

endpackage

// File: rtl/fl_prefix_count.sv
// Exclusive prefix popcount per lane plus the total count of set request bits.
// Lane i reports how many lower-numbered lanes are set, which is its offset from the pointer.
module fl_prefix_count #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]       req_i,
  output logic [N*CNT_W-1:0] prefix_o,
  output logic [CNT_W-1:0]   total_o
);

  // Ripple scan of the request vector: lane offset first, then accumulate.
  always_comb begin : prefix_scan
    logic [CNT_W-1:0] acc;
    acc      = {CNT_W{1'b0}};
    prefix_o = {(N*CNT_W){1'b0}};
    for (int i = 0; i < N; i++) begin
      prefix_o[i*CNT_W +: CNT_W] = acc;
      acc = acc + CNT_W'(req_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/freelist_ctrl_chk.sv
// Simulation-only consistency checks for the free-list pointers.
// Flags more entries between archHead and tail than the RAM can hold.
module freelist_ctrl_chk
  import freelist_pkg::*;
#(
  parameter int DEPTH = FL_DEPTH
) (
  input logic      clk,
  input logic      reset,
  input fl_state_e state_i,
  input fl_ptr_t   tail_i,
  input fl_ptr_t   archHead_i
);

  // Overflow of committed frees is a design error upstream; report it, do not correct it.
  always_ff @(posedge clk) begin
    if (!reset && (state_i == FL_RUN)) begin
      assert (ptr_diff(tail_i, archHead_i) <= fl_ptr_t'(DEPTH))
        else $error("freelist_ctrl overflow: tail=%0d archHead=%0d", tail_i, archHead_i);
    end
  end

endmodule

// File: rtl/freelist_ctrl.sv
// Free-list pointer/control logic: initialises the free-list RAM after reset, pops tags
// at the speculative head for rename, pushes freed tags at the tail on commit and rewinds
// the speculative head to the architectural head on recovery.
// Optional: define FREELIST_STALL_CNT_EN to add the saturating stall counter stallCnt_o.
module freelist_ctrl
  import freelist_pkg::*;
#(
  parameter int DW        = FL_DW,
  parameter int CW        = FL_CW,
  parameter int DEPTH     = FL_DEPTH,
  parameter int INDEX     = FL_INDEX,
  parameter int WIDTH     = FL_WIDTH,
  parameter int ARCH_REGS = FL_ARCH_REGS
) (
  input  logic              clk,
  input  logic              reset,
  output logic              freeListReady_o,
  input  logic [DW-1:0]     allocReq_i,
  output logic              stall_o,
  output logic [DW*INDEX-1:0] rdAddr_o,
  input  logic [CW-1:0]     commitValid_i,
  input  logic [CW*WIDTH-1:0] freeTag_i,
  output logic [CW-1:0]     wrEn_o,
  output logic [CW*INDEX-1:0] wrAddr_o,
  output logic [CW*WIDTH-1:0] wrData_o,
  input  logic              recover_i,
  output logic [INDEX:0]    freeCount_o
`ifdef FREELIST_STALL_CNT_EN
  ,
  output logic [31:0]       stallCnt_o
`endif
);

  localparam int ACNT_W = $clog2(DW + 1);
  localparam int CCNT_W = $clog2(CW + 1);

  fl_state_e         state_q, state_d;
  logic [INDEX-1:0]  initCnt_q, initCnt_d;
  fl_ptr_t           specHead_q, specHead_d;
  fl_ptr_t           archHead_q, archHead_d;
  fl_ptr_t           tail_q, tail_d;
  fl_ptr_t           freeCount_q, freeCount_d;

  logic [DW*ACNT_W-1:0] alloc_pre_s;
  logic [ACNT_W-1:0]    alloc_n_s;
  logic [CW*CCNT_W-1:0] commit_pre_s;
  logic [CCNT_W-1:0]    commit_m_s;
  logic                 alloc_short_s;

  fl_prefix_count #(.N(DW), .CNT_W(ACNT_W)) u_alloc_cnt (
    .req_i    (allocReq_i),
    .prefix_o (alloc_pre_s),
    .total_o  (alloc_n_s)
  );

  fl_prefix_count #(.N(CW), .CNT_W(CCNT_W)) u_commit_cnt (
    .req_i    (commitValid_i),
    .prefix_o (commit_pre_s),
    .total_o  (commit_m_s)
  );

  // Not enough free tags for this cycle's requests; uses only the registered count.
  assign alloc_short_s = (fl_ptr_t'(alloc_n_s) > freeCount_q);

  assign freeListReady_o = (state_q == FL_RUN);
  assign stall_o         = (state_q != FL_RUN) | recover_i | alloc_short_s;
  assign freeCount_o     = freeCount_q;

  // Read address per dispatch lane: speculative head plus lower-lane request count.
  always_comb begin : rd_addr_gen
    fl_ptr_t rd_ptr;
    rd_ptr   = specHead_q;
    rdAddr_o = {(DW*INDEX){1'b0}};
    for (int i = 0; i < DW; i++) begin
      rd_ptr = specHead_q + fl_ptr_t'(alloc_pre_s[i*ACNT_W +: ACNT_W]);
      rdAddr_o[i*INDEX +: INDEX] = rd_ptr[INDEX-1:0];
    end
  end

  // Write port: initialisation pattern during FL_INIT, committed frees during FL_RUN.
  always_comb begin : wr_port_gen
    fl_ptr_t wr_ptr;
    wr_ptr   = tail_q;
    wrEn_o   = {CW{1'b0}};
    wrAddr_o = {(CW*INDEX){1'b0}};
    wrData_o = {(CW*WIDTH){1'b0}};
    for (int j = 0; j < CW; j++) begin
      if (reset) begin
        wrEn_o[j] = 1'b0;
      end else if (state_q == FL_INIT) begin
        wrEn_o[j]                  = 1'b1;
        wrAddr_o[j*INDEX +: INDEX] = initCnt_q + INDEX'(j);
        wrData_o[j*WIDTH +: WIDTH] = WIDTH'(ARCH_REGS) + WIDTH'(initCnt_q) + WIDTH'(j);
      end else begin
        wr_ptr                     = tail_q + fl_ptr_t'(commit_pre_s[j*CCNT_W +: CCNT_W]);
        wrEn_o[j]                  = commitValid_i[j];
        wrAddr_o[j*INDEX +: INDEX] = wr_ptr[INDEX-1:0];
        wrData_o[j*WIDTH +: WIDTH] = freeTag_i[j*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the FSM and pointers; free count is taken from the next pointers
  // so it appears in the same cycle as the moved pointers.
  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    specHead_d = specHead_q;
    archHead_d = archHead_q;
    tail_d     = tail_q;
    case (state_q)
      FL_INIT: begin
        initCnt_d = initCnt_q + INDEX'(CW);
        if (initCnt_q == INDEX'(DEPTH - CW)) begin
          state_d = FL_RUN;
          tail_d  = fl_ptr_t'(DEPTH);
        end else begin
          state_d = FL_INIT;
        end
      end
      FL_RUN: begin
        tail_d     = tail_q + fl_ptr_t'(commit_m_s);
        archHead_d = archHead_q + fl_ptr_t'(commit_m_s);
        if (recover_i) begin
          specHead_d = archHead_q + fl_ptr_t'(commit_m_s);
        end else if (!alloc_short_s) begin
          specHead_d = specHead_q + fl_ptr_t'(alloc_n_s);
        end else begin
          specHead_d = specHead_q;
        end
      end
      default: begin
        state_d = FL_INIT;
      end
    endcase
    freeCount_d = ptr_diff(tail_d, specHead_d);
  end

  // State, init counter, pointers and registered free count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FL_INIT;
      initCnt_q   <= {INDEX{1'b0}};
      specHead_q  <= fl_ptr_t'(0);
      archHead_q  <= fl_ptr_t'(0);
      tail_q      <= fl_ptr_t'(0);
      freeCount_q <= fl_ptr_t'(0);
    end else begin
      state_q     <= state_d;
      initCnt_q   <= initCnt_d;
      specHead_q  <= specHead_d;
      archHead_q  <= archHead_d;
      tail_q      <= tail_d;
      freeCount_q <= freeCount_d;
    end
  end

`ifdef FREELIST_STALL_CNT_EN
  logic [31:0] stallCnt_q;

  // Count cycles lost to a short free list; recovery stalls are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= 32'd0;
    end else if ((state_q == FL_RUN) && alloc_short_s && !recover_i &&
                 (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end else begin
      stallCnt_q <= stallCnt_q;
    end
  end

  assign stallCnt_o = stallCnt_q;
`endif

  freelist_ctrl_chk #(.DEPTH(DEPTH)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .state_i    (state_q),
    .tail_i     (tail_q),
    .archHead_i (archHead_q)
  );

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl: table of single-cycle vectors plus hand sequences
// for init, draining, wrap-around, mid-run reset and recovery.
module tb_freelist_ctrl;

  localparam int DW = 4, CW = 4, INDEX = 6, WIDTH = 7, DEPTH = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  freeListReady_o;
  logic [DW-1:0]         allocReq_i;
  logic                  stall_o;
  logic [DW*INDEX-1:0]   rdAddr_o;
  logic [CW-1:0]         commitValid_i;
  logic [CW*WIDTH-1:0]   freeTag_i;
  logic [CW-1:0]         wrEn_o;
  logic [CW*INDEX-1:0]   wrAddr_o;
  logic [CW*WIDTH-1:0]   wrData_o;
  logic                  recover_i;
  logic [INDEX:0]        freeCount_o;
`ifdef FREELIST_STALL_CNT_EN
  logic [31:0]           stallCnt_o;
`endif

  freelist_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .freeListReady_o (freeListReady_o),
    .allocReq_i      (allocReq_i),
    .stall_o         (stall_o),
    .rdAddr_o        (rdAddr_o),
    .commitValid_i   (commitValid_i),
    .freeTag_i       (freeTag_i),
    .wrEn_o          (wrEn_o),
    .wrAddr_o        (wrAddr_o),
    .wrData_o        (wrData_o),
    .recover_i       (recover_i),
    .freeCount_o     (freeCount_o)
`ifdef FREELIST_STALL_CNT_EN
    ,
    .stallCnt_o      (stallCnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural free-list RAM driven by the controller's write ports.
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    for (int j = 0; j < CW; j++) begin
      if (wrEn_o[j]) ram[wrAddr_o[j*INDEX +: INDEX]] <= wrData_o[j*WIDTH +: WIDTH];
    end
  end

  typedef struct {
    logic [3:0]  alloc;
    logic [3:0]  commit;
    logic        rec;
    logic [27:0] tags;
    logic        stall;
    logic [23:0] rd;
    logic [3:0]  wren;
    logic [23:0] wa;
    logic [6:0]  fc;
  } vec_t;

  vec_t vt [12];

  function automatic logic [23:0] p6(input int l0, input int l1, input int l2, input int l3);
    return {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
  endfunction

  function automatic logic [27:0] p7(input int l0, input int l1, input int l2, input int l3);
    return {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input int idx);
    vec_t v;
    v = vt[idx];
    @(negedge clk);
    allocReq_i    = v.alloc;
    commitValid_i = v.commit;
    recover_i     = v.rec;
    freeTag_i     = v.tags;
    #1;
    chk($sformatf("v%0d_stall", idx),  {31'd0, stall_o}, {31'd0, v.stall});
    chk($sformatf("v%0d_rdAddr", idx), {8'd0, rdAddr_o}, {8'd0, v.rd});
    chk($sformatf("v%0d_wrEn", idx),   {28'd0, wrEn_o},  {28'd0, v.wren});
    chk($sformatf("v%0d_wrAddr", idx), {8'd0, wrAddr_o}, {8'd0, v.wa});
    chk($sformatf("v%0d_wrData", idx), {4'd0, wrData_o}, {4'd0, v.tags});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_freeCount", idx), {25'd0, freeCount_o}, {25'd0, v.fc});
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] c, input logic [27:0] t);
    @(negedge clk);
    allocReq_i    = a;
    commitValid_i = c;
    recover_i     = 1'b0;
    freeTag_i     = t;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_ready"}, {31'd0, freeListReady_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
    chk({tag, "_wrEn"},  {28'd0, wrEn_o}, 32'd0);
    chk({tag, "_fc"},    {25'd0, freeCount_o}, 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int cyc;
    int errs;
    cyc = 0;
    while (!freeListReady_o && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_init_cycles"}, cyc, 32'd16);
    chk({tag, "_fc_full"}, {25'd0, freeCount_o}, 32'd64);
    errs = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ram[k] !== 7'(32 + k)) errs++;
    end
    chk({tag, "_ram_contents"}, errs, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{alloc:4'b1011, commit:4'b0000, rec:1'b0, tags:p7(1,2,3,4),
               stall:1'b0, rd:p6(0,1,2,2),     wren:4'b0000, wa:p6(0,0,0,0),     fc:7'd61};
    vt[1]  = '{alloc:4'b0111, commit:4'b0011, rec:1'b0, tags:p7(100,101,5,6),
               stall:1'b1, rd:p6(62,63,0,1),   wren:4'b0011, wa:p6(0,1,2,2),     fc:7'd4};
    vt[2]  = '{alloc:4'b0111, commit:4'b0000, rec:1'b0, tags:p7(7,8,9,10),
               stall:1'b0, rd:p6(62,63,0,1),   wren:4'b0000, wa:p6(2,2,2,2),     fc:7'd1};
    vt[3]  = '{alloc:4'b0000, commit:4'b1111, rec:1'b0, tags:p7(40,41,42,43),
               stall:1'b0, rd:p6(1,1,1,1),     wren:4'b1111, wa:p6(2,3,4,5),     fc:7'd5};
    vt[4]  = '{alloc:4'b1111, commit:4'b1111, rec:1'b0, tags:p7(90,91,92,93),
               stall:1'b0, rd:p6(57,58,59,60), wren:4'b1111, wa:p6(62,63,0,1),   fc:7'd5};
    vt[5]  = '{alloc:4'b1111, commit:4'b0000, rec:1'b0, tags:p7(11,12,13,14),
               stall:1'b0, rd:p6(61,62,63,0),  wren:4'b0000, wa:p6(2,2,2,2),     fc:7'd1};
    vt[6]  = '{alloc:4'b1111, commit:4'b0000, rec:1'b0, tags:p7(15,16,17,18),
               stall:1'b0, rd:p6(0,1,2,3),     wren:4'b0000, wa:p6(0,0,0,0),     fc:7'd60};
    vt[7]  = '{alloc:4'b1111, commit:4'b0000, rec:1'b0, tags:p7(19,20,21,22),
               stall:1'b0, rd:p6(4,5,6,7),     wren:4'b0000, wa:p6(0,0,0,0),     fc:7'd56};
    vt[8]  = '{alloc:4'b0011, commit:4'b0000, rec:1'b0, tags:p7(23,24,25,26),
               stall:1'b0, rd:p6(8,9,10,10),   wren:4'b0000, wa:p6(0,0,0,0),     fc:7'd54};
    vt[9]  = '{alloc:4'b0000, commit:4'b0111, rec:1'b0, tags:p7(50,51,52,53),
               stall:1'b0, rd:p6(10,10,10,10), wren:4'b0111, wa:p6(0,1,2,3),     fc:7'd57};
    vt[10] = '{alloc:4'b1111, commit:4'b0001, rec:1'b1, tags:p7(60,61,62,63),
               stall:1'b1, rd:p6(10,11,12,13), wren:4'b0001, wa:p6(3,4,4,4),     fc:7'd64};
    vt[11] = '{alloc:4'b0001, commit:4'b0000, rec:1'b0, tags:p7(27,28,29,30),
               stall:1'b0, rd:p6(4,5,5,5),     wren:4'b0000, wa:p6(4,4,4,4),     fc:7'd63};

    reset         = 1'b1;
    allocReq_i    = 4'b0000;
    commitValid_i = 4'b0000;
    recover_i     = 1'b0;
    freeTag_i     = 28'd0;

    // Reset state and first initialisation
    repeat (2) @(negedge clk);
    #1;
    reset_values("rst");
    @(negedge clk);
    reset = 1'b0;
    wait_init("init1");

    // Partial allocation, then drain to two free entries
    apply(0);
    repeat (14) drive(4'b1111, 4'b0000, 28'd0);
    drive(4'b0111, 4'b0000, 28'd0);
    chk("drain_fc", {25'd0, freeCount_o}, 32'd2);

    // Stall with same-cycle commit, retry across the index wrap, then refill
    apply(1);
    apply(2);
    apply(3);
    repeat (14) drive(4'b1111, 4'b1111, p7(70,71,72,73));
    chk("steady_fc", {25'd0, freeCount_o}, 32'd5);

    // Tail wraps from 126 during commit; read lanes wrap at index 63
    apply(4);
    apply(5);
`ifdef FREELIST_STALL_CNT_EN
    chk("stall_cnt", stallCnt_o, 32'd1);
`endif

    // Asynchronous reset in the middle of a cycle with traffic applied
    @(negedge clk);
    allocReq_i    = 4'b1111;
    commitValid_i = 4'b1111;
    freeTag_i     = p7(1,1,1,1);
    #2;
    reset = 1'b1;
    #1;
    reset_values("midrst");
`ifdef FREELIST_STALL_CNT_EN
    chk("midrst_stall_cnt", stallCnt_o, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    wait_init("init2");
    allocReq_i    = 4'b0000;
    commitValid_i = 4'b0000;

    // Speculative allocation, commits, then recovery with a same-cycle commit
    for (int i = 6; i < 12; i++) apply(i);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
